// File: rtl/stack_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// stack_arb_pkg
// Shared definitions for the stack arbiter slice: controller state encoding
// and the per-requester operation encoding carried on the op vector.
// ---------------------------------------------------------------------------
package stack_arb_pkg;

  // RUN arbitrates requests, FLUSH drains the stack with no grants issued.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arbiter_if.sv
// ---------------------------------------------------------------------------
// stack_arbiter_if
// Requester-side bus of the stack arbiter.
//   req       N    per-requester request, held until granted
//   op        N    per-requester operation (1 = push, 0 = pop)
//   wdata     N*D  per-requester push data, requester i on [i*D +: D]
//   gnt       N    one-hot grant
//   rsp_valid 1    response pulse, one cycle after the grant
//   rsp_id    clog2(N) responding requester
//   rsp_data  D    popped value, 0 for push or error
//   rsp_err   1    overflow / underflow
// Modports: master = requester agents, slave = the arbiter.
// ---------------------------------------------------------------------------
interface stack_arbiter_if #(
  parameter int N = 4,
  parameter int D = 32
);

  logic [N-1:0]         req;
  logic [N-1:0]         op;
  logic [N*D-1:0]       wdata;
  logic [N-1:0]         gnt;
  logic                 rsp_valid;
  logic [$clog2(N)-1:0] rsp_id;
  logic [D-1:0]         rsp_data;
  logic                 rsp_err;

  modport master (
    output req, op, wdata,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req, op, wdata,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/stack_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter that owns the rotating priority pointer.
//   clk, reset  clock, asynchronous active-high reset
//   req    N    request vector (already masked by the caller)
//   accept 1    grant is taken this cycle; pointer may advance
//   gnt    N    one-hot grant, combinational
// After reset requester 0 has highest priority; after a grant to i the
// search starts at (i + 1) mod N. The pointer only moves on an accepted grant.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_d    = PW'((int'(idx) + 1) % N);
      end
    end
    if (!accept) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// ---------------------------------------------------------------------------
// stack_arbiter
// Shares one LIFO stack among N requesters: round-robin arbitration of
// push/pop requests, occupancy bookkeeping, registered responses and a
// flush sequence that drains the stack.
//   clk, reset   clock, asynchronous active-high reset (shared with stack)
//   bus          stack_arbiter_if.slave requester bus
//   flush        single-cycle drain request
//   stk_push     stack push strobe       (combinational)
//   stk_pop      stack pop strobe        (combinational)
//   stk_wdata    stack write data        (combinational, 0 when not pushing)
//   stk_rdata    stack top-of-stack value, valid when count > 0
//   count        occupancy 0..2**A
//   full, empty  count == 2**A, count == 0
//   busy         high while in FLUSH
//   hwm          occupancy high-water mark
// Build option: define STACK_ARB_HWM_EN to implement the hwm register;
// otherwise hwm is tied to 0.
// ---------------------------------------------------------------------------
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 32,
  parameter int A = 4
) (
  input  logic            clk,
  input  logic            reset,
  stack_arbiter_if.slave  bus,
  input  logic            flush,
  output logic            stk_push,
  output logic            stk_pop,
  output logic [D-1:0]    stk_wdata,
  input  logic [D-1:0]    stk_rdata,
  output logic [A:0]      count,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic [A:0]      hwm
);

  localparam int         IW    = $clog2(N);
  localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};
  localparam logic [A:0] ONE   = {{A{1'b0}}, 1'b1};

  state_e         state_q;
  logic [A:0]     count_q;
  logic [A:0]     count_d;
  logic           rspValid_q;
  logic [IW-1:0]  rspId_q;
  logic [D-1:0]   rspData_q;
  logic           rspErr_q;

  logic           isFull;
  logic           isEmpty;
  logic           grantEn;
  logic           granted;
  logic [IW-1:0]  gntId;
  logic           gntOp;
  logic [D-1:0]   gntData;
  logic           doPush;
  logic           doPop;
  logic           flushPop;

  // Grants are suppressed while reset is held so gnt and the stack strobes
  // show their reset values even if requesters keep req asserted.
  assign grantEn = (state_q == RUN) && !flush && !reset;

  rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req & {N{grantEn}}),
    .accept (grantEn),
    .gnt    (bus.gnt)
  );

  always_comb begin
    gntId   = '0;
    gntOp   = OP_POP;
    gntData = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) begin
        gntId   = IW'(i);
        gntOp   = bus.op[i];
        gntData = bus.wdata[i*D +: D];
      end
    end
  end

  always_comb begin
    isFull    = (count_q == DEPTH);
    isEmpty   = (count_q == '0);
    granted   = |bus.gnt;
    doPush    = granted && (gntOp == OP_PUSH) && !isFull;
    doPop     = granted && (gntOp == OP_POP) && !isEmpty;
    flushPop  = (state_q == FLUSH) && !isEmpty && !reset;
    stk_push  = doPush;
    stk_pop   = doPop || flushPop;
    stk_wdata = doPush ? gntData : '0;
    count_d   = count_q;
    if (stk_push) begin
      count_d = count_q + ONE;
    end else if (stk_pop) begin
      count_d = count_q - ONE;
    end
  end

  // FLUSH is left in the cycle that pops the last entry (or immediately
  // when already empty), so N entries cost exactly N busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      count_q    <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspData_q  <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      rspValid_q <= granted;
      if (granted) begin
        rspId_q   <= gntId;
        rspErr_q  <= (gntOp == OP_PUSH) ? isFull : isEmpty;
        rspData_q <= doPop ? stk_rdata : '0;
      end
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (count_q <= ONE) begin
            state_q <= RUN;
          end
        end
      endcase
    end
  end

`ifdef STACK_ARB_HWM_EN
  logic [A:0] hwm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_q <= '0;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_id    = rspId_q;
  assign bus.rsp_data  = rspData_q;
  assign bus.rsp_err   = rspErr_q;
  assign count         = count_q;
  assign full          = (count_q == DEPTH);
  assign empty         = (count_q == '0);
  assign busy          = (state_q == FLUSH);

endmodule

// File: tb/tb_stack_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stack_arbiter
// Scoreboard bench for stack_arbiter. A queue-based reference model predicts
// grants, strobes and occupancy each cycle and pushes expected responses;
// a separate monitor pops and compares whenever rsp_valid is seen.
// Honours STACK_ARB_HWM_EN for the expected hwm value.
// ---------------------------------------------------------------------------
module tb_stack_arbiter;

  localparam int N     = 4;
  localparam int D     = 32;
  localparam int A     = 4;
  localparam int DEPTH = 16;

  typedef struct {
    int           id;
    logic [D-1:0] data;
    bit           err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         stk_push;
  logic         stk_pop;
  logic [D-1:0] stk_wdata;
  logic [D-1:0] stk_rdata;
  logic [A:0]   count;
  logic         full;
  logic         empty;
  logic         busy;
  logic [A:0]   hwm;

  stack_arbiter_if #(.N(N), .D(D)) bus ();

  stack_arbiter #(.N(N), .D(D), .A(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .flush     (flush),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .hwm       (hwm)
  );

  always #5 clk = ~clk;

  // Stack storage instance driven by the arbiter's strobes.
  logic [D-1:0] mem [DEPTH];
  int           sp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  assign stk_rdata = (sp > 0) ? mem[sp-1] : '0;

  // Reference model and requester state.
  logic [D-1:0] mStk[$];
  int           mPtr;
  bit           mFlushing;
  int           mHwm;
  rsp_t         expQ[$];
  bit           pend [N];
  bit           pOp  [N];
  logic [D-1:0] pData[N];
  int           gntLog[$];
  logic [N-1:0] sGnt;
  logic         sBusy;
  logic         sPop;
  int           total = 0;
  int           bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_gnt", bus.gnt, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_id", bus.rsp_id, 0);
    checkOutput("rst_rsp_data", bus.rsp_data, 0);
    checkOutput("rst_rsp_err", bus.rsp_err, 0);
    checkOutput("rst_stk_push", stk_push, 0);
    checkOutput("rst_stk_pop", stk_pop, 0);
    checkOutput("rst_stk_wdata", stk_wdata, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_hwm", hwm, 0);
  endtask

  task automatic clearModel();
    mStk.delete();
    expQ.delete();
    gntLog.delete();
    mPtr      = 0;
    mFlushing = 0;
    mHwm      = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
    end
  endtask

  task automatic doReset(input bit check);
    reset     = 1'b1;
    flush     = 1'b0;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
    clearModel();
    repeat (2) @(negedge clk);
    #1;
    if (check) checkResetValues();
    reset = 1'b0;
  endtask

  // One clock cycle: drive held requests, predict, compare the
  // combinational outputs and queue the expected response.
  task automatic applyStimulus(input bit fl);
    logic [N-1:0] eGnt;
    bit           ePush;
    bit           ePop;
    logic [D-1:0] eWd;
    int           w;
    int           sz;
    int           idx;
    rsp_t         r;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.req[i]         = pend[i];
      bus.op[i]          = pOp[i];
      bus.wdata[i*D +: D] = pData[i];
    end
    flush = fl;
    #1;
    sGnt  = bus.gnt;
    sBusy = busy;
    sPop  = stk_pop;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i] === 1'b1) gntLog.push_back(i);
    end
    eGnt  = '0;
    ePush = 0;
    ePop  = 0;
    eWd   = '0;
    w     = -1;
    sz    = mStk.size();
    checkOutput("count", count, sz);
    checkOutput("full", full, sz == DEPTH);
    checkOutput("empty", empty, sz == 0);
    checkOutput("busy", busy, mFlushing);
`ifdef STACK_ARB_HWM_EN
    checkOutput("hwm", hwm, mHwm);
`else
    checkOutput("hwm", hwm, 0);
`endif
    if (mFlushing) begin
      if (sz > 0) begin
        ePop = 1;
        void'(mStk.pop_back());
      end
      if (sz <= 1) mFlushing = 0;
    end else if (fl) begin
      mFlushing = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (mPtr + k) % N;
        if (w < 0 && pend[idx]) w = idx;
      end
      if (w >= 0) begin
        eGnt[w] = 1'b1;
        mPtr    = (w + 1) % N;
        pend[w] = 0;
        r.id    = w;
        r.data  = '0;
        r.err   = 0;
        if (pOp[w]) begin
          if (sz < DEPTH) begin
            ePush = 1;
            eWd   = pData[w];
            mStk.push_back(pData[w]);
          end else begin
            r.err = 1;
          end
        end else begin
          if (sz > 0) begin
            ePop   = 1;
            r.data = mStk.pop_back();
          end else begin
            r.err = 1;
          end
        end
        expQ.push_back(r);
      end
    end
    checkOutput("gnt", bus.gnt, eGnt);
    checkOutput("stk_push", stk_push, ePush);
    checkOutput("stk_pop", stk_pop, ePop);
    checkOutput("stk_wdata", stk_wdata, eWd);
    if (mStk.size() > mHwm) mHwm = mStk.size();
  endtask

  task automatic runUntilIdle();
    bit anyPend;
    int guard = 0;
    forever begin
      anyPend = 0;
      for (int i = 0; i < N; i++) anyPend |= pend[i];
      if (!anyPend && !mFlushing) break;
      applyStimulus(1'b0);
      guard++;
      if (guard > 200) begin
        checkOutput("idle_timeout", guard, 0);
        clearModel();
        break;
      end
    end
    applyStimulus(1'b0);
  endtask

  task automatic setReq(input int i, input bit isPush, input logic [D-1:0] v);
    pend[i]  = 1;
    pOp[i]   = isPush;
    pData[i] = v;
  endtask

  // Monitor: responses arrive exactly one cycle after their grant.
  always @(negedge clk) begin
    rsp_t r;
    if (reset === 1'b0) begin
      if (bus.rsp_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp", bus.rsp_valid, 0);
        end else begin
          r = expQ.pop_front();
          checkOutput("rsp_id", bus.rsp_id, r.id);
          checkOutput("rsp_data", bus.rsp_data, r.data);
          checkOutput("rsp_err", bus.rsp_err, r.err);
        end
      end else if (expQ.size() > 0) begin
        checkOutput("missing_rsp", bus.rsp_valid, 1);
        expQ.delete();
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int noG;
    int bz;
    int pp;
    int guard;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 0;
      pOp[i]   = 0;
      pData[i] = '0;
    end

    // Reset and a single push from requester 0.
    doReset(1'b1);
    setReq(0, 1'b1, 32'hA5);
    runUntilIdle();
    checkOutput("count_after_push", count, 1);

    // Fill from requester 1 and overflow.
    doReset(1'b0);
    for (int v = 0; v < 17; v++) begin
      setReq(1, 1'b1, 32'h100 + v);
      runUntilIdle();
    end
    checkOutput("full_after_17", full, 1);
    checkOutput("count_after_17", count, 16);

    // Round-robin pops on an empty stack.
    doReset(1'b0);
    for (int i = 0; i < N; i++) setReq(i, 1'b0, '0);
    repeat (4) applyStimulus(1'b0);
    setReq(0, 1'b0, '0);
    runUntilIdle();
    checkOutput("rr_len", gntLog.size(), 5);
    for (int k = 0; k < 5 && k < gntLog.size(); k++) begin
      checkOutput("rr_order", gntLog[k], k % N);
    end

    // LIFO ordering, back-to-back from different requesters.
    doReset(1'b0);
    setReq(0, 1'b1, 32'h11);
    setReq(1, 1'b1, 32'h22);
    setReq(2, 1'b1, 32'h33);
    runUntilIdle();
    setReq(3, 1'b0, '0);
    setReq(0, 1'b0, '0);
    setReq(1, 1'b0, '0);
    runUntilIdle();
    checkOutput("lifo_empty", empty, 1);
`ifdef STACK_ARB_HWM_EN
    checkOutput("lifo_hwm", hwm, 3);
`else
    checkOutput("lifo_hwm", hwm, 0);
`endif

    // Flush with 5 entries while requester 2 waits.
    doReset(1'b0);
    for (int v = 0; v < 5; v++) begin
      setReq(0, 1'b1, 32'h200 + v);
      runUntilIdle();
    end
    setReq(2, 1'b1, 32'h55);
    noG = 0;
    bz  = 0;
    pp  = 0;
    applyStimulus(1'b1);
    if (sGnt == '0) noG++;
    bz += int'(sBusy);
    pp += int'(sPop);
    guard = 0;
    while (sGnt[2] !== 1'b1 && guard < 20) begin
      applyStimulus(1'b0);
      guard++;
      if (sGnt == '0) noG++;
      bz += int'(sBusy);
      pp += int'(sPop);
    end
    checkOutput("flush_nogrant_cycles", noG, 6);
    checkOutput("flush_busy_cycles", bz, 5);
    checkOutput("flush_pop_cycles", pp, 5);
    runUntilIdle();
    checkOutput("flush_then_push_count", count, 1);

    // Reset in the middle of a flush with 3 entries.
    doReset(1'b0);
    for (int v = 0; v < 3; v++) begin
      setReq(1, 1'b1, 32'h300 + v);
      runUntilIdle();
    end
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues();
    clearModel();
    flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) applyStimulus(1'b0);

    // Randomized traffic with occasional flushes.
    doReset(1'b0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          setReq(i, ($urandom_range(9) < 6), $urandom);
        end
      end
      applyStimulus($urandom_range(49) == 0);
    end
    runUntilIdle();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
